// File: rtl/acc_control_fsm.sv
// Multicycle control unit for the accumulator datapath: opcode decode, datapath
// strobes and memory request/ack handshake. Optional MEM_TIMEOUT_EN adds a memory-wait watchdog.
module acc_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] Opcode,
  input  logic       AccZero,
  input  logic       MemAck,
  output logic       MemReq,
  output logic       MemWE,
  output logic [1:0] AddrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MDRWrite,
  output logic [2:0] AccSrc,
  output logic       AccWrite,
  output logic       SpWrite,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Halted,
`ifdef MEM_TIMEOUT_EN
  output logic       MemTimeout,
`endif
  output logic       IllegalOp
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADDI = 4'd0;
  localparam logic [OP_W-1:0] OP_ADDM = 4'd1;
  localparam logic [OP_W-1:0] OP_LW   = 4'd2;
  localparam logic [OP_W-1:0] OP_SW   = 4'd3;
  localparam logic [OP_W-1:0] OP_LI   = 4'd4;
  localparam logic [OP_W-1:0] OP_LUI  = 4'd5;
  localparam logic [OP_W-1:0] OP_PUSH = 4'd6;
  localparam logic [OP_W-1:0] OP_POP  = 4'd7;
  localparam logic [OP_W-1:0] OP_BEQZ = 4'd8;
  localparam logic [OP_W-1:0] OP_J    = 4'd9;
  localparam logic [OP_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_WB_IMM, ST_MEM_RD,
    ST_WB, ST_SP_DEC, ST_MEM_WR, ST_BRANCH, ST_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;
  logic            ack_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  assign MemTimeout = timeout_q;
`else
  // TIMEOUT_CYCLES has no effect unless the watchdog is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Ack-gated strobes must stay low while reset is held.
  assign ack_c     = MemAck & reset;
  assign IllegalOp = illegal_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
`ifdef MEM_TIMEOUT_EN
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    MemReq    = 1'b0;
    MemWE     = 1'b0;
    AddrSrc   = 2'd0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MDRWrite  = 1'b0;
    AccSrc    = 3'd0;
    AccWrite  = 1'b0;
    SpWrite   = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 3'd0;
    ALUOp     = 2'd0;
    Halted    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_FETCH: begin
        MemReq = 1'b1;
        if (ack_c) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_ADDI:               state_d = ST_EXEC;
          OP_ADDM, OP_LW, OP_POP: state_d = ST_MEM_RD;
          OP_SW:                 state_d = ST_MEM_WR;
          OP_LI, OP_LUI:         state_d = ST_WB_IMM;
          OP_PUSH:               state_d = ST_SP_DEC;
          OP_BEQZ, OP_J:         state_d = ST_BRANCH;
          OP_HALT:               state_d = ST_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_EXEC: begin
        ALUSrcA  = 2'd1;
        ALUSrcB  = 3'd1;
        AccSrc   = 3'd4;
        AccWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_WB_IMM: begin
        AccSrc   = (op_q == OP_LI) ? 3'd3 : 3'd0;
        AccWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_RD: begin
        MemReq  = 1'b1;
        AddrSrc = (op_q == OP_POP) ? 2'd2 : 2'd1;
        if (ack_c) begin
          MDRWrite = 1'b1;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        AccWrite = 1'b1;
        state_d  = ST_FETCH;
        case (op_q)
          OP_ADDM: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 3'd3;
            AccSrc  = 3'd4;
          end
          OP_POP: begin
            AccSrc  = 3'd1;
            SpWrite = 1'b1;
            ALUSrcA = 2'd2;
          end
          default: AccSrc = 3'd1;
        endcase
      end
      ST_SP_DEC: begin
        ALUSrcA = 2'd2;
        ALUOp   = 2'd1;
        SpWrite = 1'b1;
        state_d = ST_MEM_WR;
      end
      ST_MEM_WR: begin
        MemReq  = 1'b1;
        MemWE   = 1'b1;
        AddrSrc = (op_q == OP_PUSH) ? 2'd2 : 2'd1;
        if (ack_c) state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcB = 3'd2;
        PCWrite = (op_q == OP_J) | AccZero;
        state_d = ST_FETCH;
      end
      ST_HALT: Halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase

`ifdef MEM_TIMEOUT_EN
    // Count unanswered request cycles; an ack on the limit cycle wins.
    if (MemReq && !MemAck) begin
      wait_d = wait_q + CNT_W'(1);
      if (wait_d == CNT_W'(TIMEOUT_CYCLES)) begin
        state_d   = ST_HALT;
        timeout_d = 1'b1;
      end
    end
    if ((state_d != state_q) &&
        (state_d == ST_FETCH || state_d == ST_MEM_RD || state_d == ST_MEM_WR))
      wait_d = '0;
`endif
  end

endmodule

// File: tb/tb_acc_control_fsm.sv
// Randomized self-checking bench for acc_control_fsm: a per-opcode table of
// expected cycle-by-cycle control words, driven with random memory wait states.
module tb_acc_control_fsm;

  logic       CLK;
  logic       reset;
  logic [3:0] Opcode;
  logic       AccZero;
  logic       MemAck;
  logic       MemReq, MemWE, IRWrite, PCWrite, MDRWrite, AccWrite, SpWrite, Halted, IllegalOp;
  logic [1:0] AddrSrc, ALUSrcA, ALUOp;
  logic [2:0] AccSrc, ALUSrcB;
`ifdef MEM_TIMEOUT_EN
  logic       MemTimeout;
`endif

  acc_control_fsm #(.TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .reset(reset), .Opcode(Opcode), .AccZero(AccZero), .MemAck(MemAck),
    .MemReq(MemReq), .MemWE(MemWE), .AddrSrc(AddrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .MDRWrite(MDRWrite), .AccSrc(AccSrc), .AccWrite(AccWrite),
    .SpWrite(SpWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Halted(Halted),
`ifdef MEM_TIMEOUT_EN
    .MemTimeout(MemTimeout),
`endif
    .IllegalOp(IllegalOp)
  );

  typedef struct packed {
    logic       memreq;
    logic       memwe;
    logic [1:0] addr;
    logic       irw;
    logic       pcw;
    logic       mdrw;
    logic [2:0] accsrc;
    logic       accw;
    logic       spw;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [1:0] aluop;
    logic       halted;
    logic       illegal;
  } outs_t;

  outs_t dut_v, exp_v;
  assign dut_v = {MemReq, MemWE, AddrSrc, IRWrite, PCWrite, MDRWrite, AccSrc,
                  AccWrite, SpWrite, ALUSrcA, ALUSrcB, ALUOp, Halted, IllegalOp};

  int    n_checks = 0;
  int    n_errors = 0;
  bit    chk_en   = 0;
  string phase    = "idle";
  logic  m_illegal = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge CLK) if (chk_en) check(phase, 32'(dut_v), 32'(exp_v));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    o.illegal = m_illegal;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs after the edge, expectation checked at negedge.
  task automatic step(input string nm, input outs_t e, input logic ack,
                      input logic accz, input logic [3:0] opc);
    @(posedge CLK); #1;
    MemAck  = ack;
    AccZero = accz;
    Opcode  = opc;
    exp_v   = e;
    phase   = nm;
    chk_en  = 1'b1;
    @(negedge CLK); #1;
  endtask

  task automatic mem_access(input string nm, input outs_t wait_v, input outs_t ack_v,
                            input int waits, input logic [3:0] opc);
    int w;
    w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    repeat (w) step(nm, wait_v, 1'b0, rb(), opc);
    step(nm, ack_v, 1'b1, rb(), opc);
  endtask

  task automatic fetch(input int waits);
    outs_t f, fa;
    f = idle();
    f.memreq = 1'b1;
    fa = f;
    fa.irw = 1'b1;
    fa.pcw = 1'b1;
    mem_access("fetch", f, fa, waits, 4'($urandom_range(0, 15)));
  endtask

  // Expected control words for one legal instruction, from the ISA description.
  task automatic run_instr(input int op, input int waits, input int accz);
    outs_t e, ea;
    logic [3:0] opc;
    logic az;
    opc = 4'(op);
    fetch(waits);
    step("decode", idle(), rb(), rb(), opc);
    e = idle();
    case (op)
      0: begin
        e.srca = 2'd1; e.srcb = 3'd1; e.accsrc = 3'd4; e.accw = 1'b1;
        step("addi_exec", e, rb(), rb(), opc);
      end
      1, 2, 7: begin
        e.memreq = 1'b1;
        e.addr   = (op == 7) ? 2'd2 : 2'd1;
        ea = e;
        ea.mdrw = 1'b1;
        mem_access("mem_rd", e, ea, waits, opc);
        e = idle();
        e.accw = 1'b1;
        if (op == 1) begin
          e.srca = 2'd1; e.srcb = 3'd3; e.accsrc = 3'd4;
        end else begin
          e.accsrc = 3'd1;
          if (op == 7) begin
            e.spw = 1'b1; e.srca = 2'd2;
          end
        end
        step("wb", e, rb(), rb(), opc);
      end
      3, 6: begin
        if (op == 6) begin
          e.srca = 2'd2; e.aluop = 2'd1; e.spw = 1'b1;
          step("sp_dec", e, rb(), rb(), opc);
          e = idle();
        end
        e.memreq = 1'b1;
        e.memwe  = 1'b1;
        e.addr   = (op == 6) ? 2'd2 : 2'd1;
        mem_access("mem_wr", e, e, waits, opc);
      end
      4, 5: begin
        e.accsrc = (op == 4) ? 3'd3 : 3'd0;
        e.accw   = 1'b1;
        step("wb_imm", e, rb(), rb(), opc);
      end
      default: begin
        az = (accz > 1) ? rb() : 1'(accz);
        e.srcb = 3'd2;
        e.pcw  = (op == 9) || az;
        step("branch", e, rb(), az, opc);
      end
    endcase
  endtask

  task automatic do_reset();
    outs_t r;
    @(posedge CLK); #1;
    chk_en = 1'b0;
    reset  = 1'b0;
    MemAck = 1'b1;
    m_illegal = 1'b0;
    #1;
    r = '0;
    r.memreq = 1'b1;
    check("reset_outputs", 32'(dut_v), 32'(r));
    repeat (2) @(posedge CLK);
    #1;
    check("reset_held", 32'(dut_v), 32'(r));
    reset  = 1'b1;
    MemAck = 1'b0;
    #1;
    check("post_reset_fetch", {29'd0, MemReq, AddrSrc}, 32'h4);
  endtask

  task automatic run_halt(input int op);
    outs_t h;
    fetch(-1);
    step("decode", idle(), rb(), rb(), 4'(op));
    m_illegal = m_illegal | (op >= 10 && op <= 14);
    h = idle();
    h.halted = 1'b1;
    step("halt", h, rb(), rb(), 4'(op));
    check("halt_flags", {30'd0, Halted, IllegalOp}, {30'd0, 1'b1, (op != 15)});
    repeat (19) step("halt", h, rb(), rb(), 4'($urandom_range(0, 15)));
    do_reset();
  endtask

  task automatic reset_mid_write();
    outs_t e;
    fetch(0);
    step("decode", idle(), 1'b0, 1'b0, 4'd3);
    e = idle();
    e.memreq = 1'b1; e.memwe = 1'b1; e.addr = 2'd1;
    repeat (2) step("mem_wr", e, 1'b0, rb(), 4'd3);
    check("pre_reset_memwe", {31'd0, MemWE}, 32'd1);
    do_reset();
  endtask

  initial begin
    outs_t e;
    reset = 1'b0; MemAck = 1'b0; AccZero = 1'b0; Opcode = 4'd0;
    exp_v = '0;
    do_reset();
    check("reset_illegal", {31'd0, IllegalOp}, 32'd0);

    // ADDI with zero-wait fetch, pinned against literal control values
    e = idle(); e.memreq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    step("addi_fetch", e, 1'b1, 1'b0, 4'hA);
    check("addi_fetch_strobes", {30'd0, IRWrite, PCWrite}, 32'h3);
    step("addi_decode", idle(), 1'b0, 1'b0, 4'd0);
    check("decode_enables", {26'd0, MemReq, IRWrite, PCWrite, AccWrite, SpWrite, MDRWrite}, 32'd0);
    e = idle(); e.srca = 2'd1; e.srcb = 3'd1; e.accsrc = 3'd4; e.accw = 1'b1;
    step("addi_exec", e, 1'b0, 1'b0, 4'd0);
    check("exec_controls", {23'd0, AccWrite, AccSrc, ALUSrcA, ALUSrcB}, {23'd0, 1'b1, 3'd4, 2'd1, 3'd1});
    e = idle(); e.memreq = 1'b1;
    step("addi_next_fetch", e, 1'b0, 1'b0, 4'd0);
    check("next_fetch_req", {31'd0, MemReq}, 32'd1);

    run_instr(2, 3, 2);
    run_instr(6, 0, 2);
    run_instr(7, 1, 2);
    run_instr(8, 0, 0);
    run_instr(8, 0, 1);
    run_instr(9, 0, 0);
    run_instr(9, 2, 1);
    run_halt(12);
    reset_mid_write();
    run_instr(1, -1, 2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 3) run_halt(int'($urandom_range(10, 15)));
      else run_instr(int'($urandom_range(0, 9)), -1, 2);
    end

`ifdef MEM_TIMEOUT_EN
    e = idle(); e.memreq = 1'b1;
    repeat (15) step("timeout_wait", e, 1'b0, rb(), 4'd0);
    e = idle(); e.halted = 1'b1;
    step("timeout_halt", e, 1'b0, rb(), 4'd0);
    check("mem_timeout_set", {31'd0, MemTimeout}, 32'd1);
    do_reset();
    check("mem_timeout_clear", {31'd0, MemTimeout}, 32'd0);
`endif

    @(posedge CLK); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acc_control_fsm.md
Name: acc_control_fsm

Overview:
- Multicycle control unit for the accumulator datapath.
- Decodes the instruction opcode and drives the datapath controls: Acc source mux, Acc/SP write enables, ALU operand selects, PC/IR/MDR writes.
- Runs a request/acknowledge handshake with instruction/data memory.
- It is the command-issuing end of the datapath control interface; the datapath consumes these signals.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles MemReq may wait for MemAck (used only with MEM_TIMEOUT_EN).

Ports:
- CLK  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- Opcode  input  4  IR[15:12], stable from the cycle after IRWrite
- AccZero  input  1  Acc == 0
- MemAck  input  1  memory completed the current request this cycle
- MemReq  output  1  memory request
- MemWE  output  1  request is a write
- AddrSrc  output  2  0=PC, 1=ZE, 2=SP
- IRWrite  output  1  load IR from MemData
- PCWrite  output  1  load PC from ALU
- MDRWrite  output  1  load MDR from MemData
- AccSrc  output  3  0=IR<<8, 1=MDR, 2=MemData, 3=SE, 4=ALU
- AccWrite  output  1  Acc enable
- SpWrite  output  1  SP enable (SP loads ALU)
- ALUSrcA  output  2  0=PC, 1=Acc, 2=SP
- ALUSrcB  output  3  0=const 2, 1=SE, 2=SELeft, 3=MDR
- ALUOp  output  2  0=add, 1=sub
- Halted  output  1  in HALT
- IllegalOp  output  1  sticky; undefined opcode seen

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, op_q=0, IllegalOp=0.
  - Every output except MemReq is 0 immediately.
  - Reset mid-handshake drops MemWE at once, discarding the access.
- MemReq after reset:
  - MemReq is Moore-decoded from state, so FETCH asserts MemReq=1, AddrSrc=0 as soon as reset releases.
  - The bench must not treat MemReq=1 after reset release as an error.
- Opcodes:
  - 0 ADDI: Acc += SE
  - 1 ADDM: Acc += Mem[ZE]
  - 2 LW: Acc = Mem[ZE]
  - 3 SW: Mem[ZE] = Acc
  - 4 LI: Acc = SE
  - 5 LUI: Acc = IR<<8
  - 6 PUSH: SP -= 2, then Mem[SP] = Acc
  - 7 POP: Acc = Mem[SP], SP += 2
  - 8 BEQZ: if AccZero, PC += SELeft
  - 9 J: PC += SELeft
  - 15 HALT
  - 10-14: illegal
- Output decode:
  - Selects and enables are Moore (state, op_q).
  - IRWrite, PCWrite-in-FETCH and MDRWrite are additionally gated by MemAck.
  - Unlisted outputs are 0 in every state.
- FETCH:
  - MemReq=1, AddrSrc=0, ALUSrcA=0, ALUSrcB=0, ALUOp=0.
  - Hold until MemAck=1; in that cycle IRWrite=1, PCWrite=1 (PC += 2), go to DECODE.
- DECODE (1 cycle):
  - Latch op_q=Opcode.
  - Next state: 0 -> EXEC; 1,2,7 -> MEM_RD; 3 -> MEM_WR; 4,5 -> WB_IMM; 6 -> SP_DEC; 8,9 -> BRANCH; 15 -> HALT.
  - Illegal opcode: set IllegalOp, go to HALT.
- EXEC: ALUSrcA=1, ALUSrcB=1, ALUOp=0, AccSrc=4, AccWrite=1 -> FETCH.
- WB_IMM: AccSrc=3 (LI) or 0 (LUI), AccWrite=1 -> FETCH.
- MEM_RD:
  - MemReq=1, MemWE=0, AddrSrc=2 for POP else 1.
  - Wait for MemAck; on ack MDRWrite=1 -> WB.
- WB:
  - ADDM: ALUSrcA=1, ALUSrcB=3, AccSrc=4.
  - LW: AccSrc=1.
  - POP: AccSrc=1 plus SpWrite=1, ALUSrcA=2, ALUSrcB=0, ALUOp=0.
  - AccWrite=1 in all cases -> FETCH.
- SP_DEC: ALUSrcA=2, ALUSrcB=0, ALUOp=1, SpWrite=1 -> MEM_WR.
- MEM_WR:
  - MemReq=1, MemWE=1, AddrSrc=2 for PUSH else 1.
  - Hold until MemAck -> FETCH.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=2, ALUOp=0.
  - PCWrite = (op_q==9) | AccZero -> FETCH.
- HALT: Halted=1; absorbing until reset.
- Handshake rules:
  - Address, MemWE and MemReq stay stable while waiting.
  - MemAck with MemReq=0 is ignored.
  - Ack in the first request cycle gives zero wait states.
- Latencies at zero wait: ADDI/LI/LUI/SW/BEQZ/J = 3 cycles; ADDM/LW/POP/PUSH = 4 cycles.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entering FETCH/MEM_RD/MEM_WR and increments each cycle MemReq=1 && MemAck=0.
  - When it reaches TIMEOUT_CYCLES, go to HALT and assert output MemTimeout (1 bit, sticky, reset 0).
  - An ack on the same cycle as the limit wins.
- Undefined: no counter, no MemTimeout port; waits indefinitely.

Test Plan:
- Reset: hold reset=0 mid-MEM_WR.
  - MemWE=0 immediately; all outputs 0 except MemReq.
  - After release: state FETCH, MemReq=1, AddrSrc=0.
- ADDI, zero-wait ack:
  - FETCH ack cycle: IRWrite=1, PCWrite=1.
  - Next cycle: DECODE, no enables.
  - Then: AccWrite=1, AccSrc=4, ALUSrcA=1, ALUSrcB=1; MemReq back 1 the following cycle.
- LW with 3 wait cycles:
  - MemReq=1, AddrSrc=1 stable 4 cycles; MDRWrite=1 only in the ack cycle.
  - Next cycle: AccWrite=1, AccSrc=1.
- PUSH then POP:
  - PUSH: SpWrite=1, ALUOp=1, then MemWE=1, AddrSrc=2.
  - POP: MemReq=1, AddrSrc=2, then AccSrc=1, AccWrite=1, SpWrite=1, ALUOp=0 in the same cycle.
- BEQZ with AccZero=0: PCWrite=0 in BRANCH. With AccZero=1: PCWrite=1, ALUSrcB=2. J (op 9): PCWrite=1 regardless of AccZero.
- Opcode 12: IllegalOp=1 and Halted=1 after DECODE; no further MemReq for 20 cycles. With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15 and no ack: MemTimeout=1 after 15 waiting cycles.
